// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
// Shared constants and types for the MLP datapath.
//   DATA_W / FRAC_BITS : signed fixed-point neuron and weight format (Q3.4)
//   ACC_W              : accumulator width
//   NADDR_W / WADDR_W  : neuron RAM / weight ROM address widths
//   LAST_LAYER         : destination layer written without ReLU (softmax input)
//   stage_tag_t        : control tag that travels alongside each pipeline term
// -----------------------------------------------------------------------------
package mlp_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAC_BITS  = 4;
    localparam int ACC_W      = 24;
    localparam int NADDR_W    = 12;
    localparam int WADDR_W    = 16;
    localparam int LAST_LAYER = 3;

    // Layer field inside a neuron address.
    localparam int LAYER_MSB = 11;
    localparam int LAYER_LSB = 10;

    typedef struct packed {
        logic               valid;
        logic               first;
        logic               last;
        logic [NADDR_W-1:0] out_addr;
    } stage_tag_t;

    localparam stage_tag_t STAGE_EMPTY = '{valid: 1'b0, first: 1'b0, last: 1'b0, out_addr: '0};

    function automatic logic [1:0] layer_of(input logic [NADDR_W-1:0] addr);
        return addr[LAYER_MSB:LAYER_LSB];
    endfunction

    // True when this stage will produce a write to addr.
    function automatic logic tag_hits(input stage_tag_t tag, input logic [NADDR_W-1:0] addr);
        return tag.valid && tag.last && (tag.out_addr == addr);
    endfunction

endpackage

// File: rtl/mac_saturate.sv
// -----------------------------------------------------------------------------
// mac_saturate
// Combinational arithmetic for the MAC writeback unit.
//   add_a, add_b  in  ACC_W   signed accumulator operands
//   add_sum       out ACC_W   signed sum, clamped to +/-(2^(ACC_W-1)-1)
//   add_ovf       out 1       the sum overflowed and was clamped
//   wb_acc        in  ACC_W   finished accumulator value
//   relu_en       in  1       clamp negative results to zero
//   wb_data       out DATA_W  (wb_acc >>> FRAC_BITS), ReLU'd, saturated
// -----------------------------------------------------------------------------
module mac_saturate #(
    parameter int ACC_W     = 24,
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic [ACC_W-1:0]  add_a,
    input  logic [ACC_W-1:0]  add_b,
    output logic [ACC_W-1:0]  add_sum,
    output logic              add_ovf,
    input  logic [ACC_W-1:0]  wb_acc,
    input  logic              relu_en,
    output logic [DATA_W-1:0] wb_data
);

    // Symmetric clamp: the most negative code is never produced.
    localparam logic [ACC_W-1:0] ACC_POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_NEG_MAX = ~ACC_POS_MAX + 1'b1;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    logic [ACC_W-1:0]        raw_sum;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        raw_sum = add_a + add_b;
        add_ovf = (add_a[ACC_W-1] == add_b[ACC_W-1]) && (raw_sum[ACC_W-1] != add_a[ACC_W-1]);
        add_sum = raw_sum;
        if (add_ovf) begin
            add_sum = add_a[ACC_W-1] ? ACC_NEG_MAX : ACC_POS_MAX;
        end

        shifted = $signed(wb_acc) >>> FRAC_BITS;
        if (relu_en && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        wb_data = shifted[DATA_W-1:0];
        if (shifted > OUT_MAX) begin
            wb_data = OUT_MAX[DATA_W-1:0];
        end else if (shifted < OUT_MIN) begin
            wb_data = OUT_MIN[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/mac_writeback_unit.sv
// -----------------------------------------------------------------------------
// mac_writeback_unit
// Multiply-accumulate datapath behind the MLP address sequencer. Each accepted
// term reads one neuron and one weight, multiplies them and accumulates; the
// last term of a neuron triggers a ReLU/saturated writeback to neuron RAM.
//   clk, reset                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             term handshake (RAW hazard stalls ready)
//   cmd_first/cmd_last              neuron boundaries
//   cmd_in_addr/w_addr/out_addr     input neuron, weight, destination addresses
//   ctrl_done                       sequencer has issued everything
//   neuron_rd_addr/neuron_rd_data   neuron RAM read port, 1-cycle latency
//   weight_rd_addr/weight_rd_data   weight ROM read port, 1-cycle latency
//   neuron_wr_en/addr/data          single-cycle writeback strobe
//   mlp_done                        sticky: control done and pipeline drained
//   acc_overflow                    sticky: accumulator saturated at least once
// Pipeline: E0 addr regs, E1 memory data, E2 product, E3 accumulate, E4 write.
// -----------------------------------------------------------------------------
module mac_writeback_unit
    import mlp_pkg::*;
#(
    parameter int ACC_W      = mlp_pkg::ACC_W,
    parameter int FRAC_BITS  = mlp_pkg::FRAC_BITS,
    parameter int LAST_LAYER = mlp_pkg::LAST_LAYER
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_first,
    input  logic               cmd_last,
    input  logic [NADDR_W-1:0] cmd_in_addr,
    input  logic [WADDR_W-1:0] cmd_w_addr,
    input  logic [NADDR_W-1:0] cmd_out_addr,
    input  logic               ctrl_done,
    output logic [NADDR_W-1:0] neuron_rd_addr,
    input  logic [DATA_W-1:0]  neuron_rd_data,
    output logic [WADDR_W-1:0] weight_rd_addr,
    input  logic [DATA_W-1:0]  weight_rd_data,
    output logic               neuron_wr_en,
    output logic [NADDR_W-1:0] neuron_wr_addr,
    output logic [DATA_W-1:0]  neuron_wr_data,
    output logic               mlp_done,
    output logic               acc_overflow
);

    localparam logic [1:0] LAST_LAYER_ID = 2'(LAST_LAYER);

    stage_tag_t s0, s1, s2;
    // The first flag is consumed at E3, so the E4-bound stage keeps only the rest.
    logic               s3_valid;
    logic               s3_last;
    logic [NADDR_W-1:0] s3_out_addr;

    logic signed [2*DATA_W-1:0] product;
    logic [ACC_W-1:0]           acc;
    logic [ACC_W-1:0]           acc_base;
    logic [ACC_W-1:0]           acc_addend;
    logic [ACC_W-1:0]           acc_sum;
    logic                       acc_ovf;
    logic                       acc_clamped;  // current neuron has saturated
    logic                       acc_fresh;    // previous term closed a neuron
    logic                       acc_hold;

    logic              ready_en;
    logic              raw_hazard;
    logic              xfer;
    logic              pipe_busy;
    logic              relu_en;
    logic [DATA_W-1:0] wb_data;

    // A term may not read a neuron that an in-flight neuron is about to write;
    // there is no forwarding, so it waits until the RAM holds the new value.
    assign raw_hazard = tag_hits(s0, cmd_in_addr) || tag_hits(s1, cmd_in_addr) ||
                        tag_hits(s2, cmd_in_addr) ||
                        (s3_valid && s3_last && (s3_out_addr == cmd_in_addr)) ||
                        (neuron_wr_en && (neuron_wr_addr == cmd_in_addr));

    assign cmd_ready = ready_en && !raw_hazard;
    assign xfer      = cmd_valid && cmd_ready;
    assign pipe_busy = s0.valid || s1.valid || s2.valid || s3_valid || neuron_wr_en;

    // A new neuron (explicit first, or any term after a last) starts from zero;
    // once clamped, the rest of the neuron leaves the accumulator pinned.
    assign acc_addend = ACC_W'(product);
    assign acc_base   = (s2.first || acc_fresh) ? '0 : acc;
    assign acc_hold   = !s2.first && !acc_fresh && acc_clamped;
    assign relu_en    = (layer_of(s3_out_addr) != LAST_LAYER_ID);

    mac_saturate #(
        .ACC_W    (ACC_W),
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_sat (
        .add_a  (acc_base),
        .add_b  (acc_addend),
        .add_sum(acc_sum),
        .add_ovf(acc_ovf),
        .wb_acc (acc),
        .relu_en(relu_en),
        .wb_data(wb_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses <= so every stage samples pre-edge values.
        if (!reset) begin
            ready_en       <= 1'b0;
            s0             <= STAGE_EMPTY;
            s1             <= STAGE_EMPTY;
            s2             <= STAGE_EMPTY;
            s3_valid       <= 1'b0;
            s3_last        <= 1'b0;
            s3_out_addr    <= '0;
            neuron_rd_addr <= '0;
            weight_rd_addr <= '0;
            product        <= '0;
            acc            <= '0;
            acc_clamped    <= 1'b0;
            acc_fresh      <= 1'b1;
            neuron_wr_en   <= 1'b0;
            neuron_wr_addr <= '0;
            neuron_wr_data <= '0;
            mlp_done       <= 1'b0;
            acc_overflow   <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            // E0: register read addresses and the term's tag.
            if (xfer) begin
                neuron_rd_addr <= cmd_in_addr;
                weight_rd_addr <= cmd_w_addr;
                s0 <= '{valid: 1'b1, first: cmd_first, last: cmd_last, out_addr: cmd_out_addr};
            end else begin
                s0 <= STAGE_EMPTY;
            end

            // E1: memory data arrives while s1 is valid.
            s1 <= s0;

            // E2: signed product.
            s2 <= s1;
            if (s1.valid) begin
                product <= $signed(neuron_rd_data) * $signed(weight_rd_data);
            end

            // E3: accumulate; bubbles leave the accumulator untouched.
            s3_valid    <= s2.valid;
            s3_last     <= s2.last;
            s3_out_addr <= s2.out_addr;
            if (s2.valid) begin
                acc_fresh <= s2.last;
                if (!acc_hold) begin
                    acc          <= acc_sum;
                    acc_clamped  <= acc_ovf;
                    acc_overflow <= acc_overflow | acc_ovf;
                end
            end

            // E4: writeback of a finished neuron.
            neuron_wr_en <= s3_valid && s3_last;
            if (s3_valid && s3_last) begin
                neuron_wr_addr <= s3_out_addr;
                neuron_wr_data <= wb_data;
            end

            if (ctrl_done && !xfer && !pipe_busy) begin
                mlp_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_mac_writeback_unit
// Directed bench for mac_writeback_unit. A default-width instance drives the
// neuron RAM model; a second instance with ACC_W=16 sees the same commands
// and is used to observe accumulator saturation.
// -----------------------------------------------------------------------------
module tb_mac_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_first, cmd_last, ctrl_done;
    logic [11:0] cmd_in_addr, cmd_out_addr;
    logic [15:0] cmd_w_addr;

    logic        cmd_ready, wr_en, mlp_done, acc_overflow;
    logic [11:0] n_rd_addr, wr_addr;
    logic [15:0] w_rd_addr;
    logic [7:0]  n_rd, w_rd, wr_data;

    logic        cmd_ready2, wr_en2, mlp_done2, acc_overflow2;
    logic [11:0] n_rd_addr2, wr_addr2;
    logic [15:0] w_rd_addr2;
    logic [7:0]  n_rd2, w_rd2, wr_data2;

    logic [7:0] nmem [0:4095];
    logic [7:0] wmem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_writeback_unit dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_first(cmd_first), .cmd_last(cmd_last),
        .cmd_in_addr(cmd_in_addr), .cmd_w_addr(cmd_w_addr), .cmd_out_addr(cmd_out_addr),
        .ctrl_done(ctrl_done),
        .neuron_rd_addr(n_rd_addr), .neuron_rd_data(n_rd),
        .weight_rd_addr(w_rd_addr), .weight_rd_data(w_rd),
        .neuron_wr_en(wr_en), .neuron_wr_addr(wr_addr), .neuron_wr_data(wr_data),
        .mlp_done(mlp_done), .acc_overflow(acc_overflow)
    );

    mac_writeback_unit #(.ACC_W(16)) dut_narrow (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_first(cmd_first), .cmd_last(cmd_last),
        .cmd_in_addr(cmd_in_addr), .cmd_w_addr(cmd_w_addr), .cmd_out_addr(cmd_out_addr),
        .ctrl_done(ctrl_done),
        .neuron_rd_addr(n_rd_addr2), .neuron_rd_data(n_rd2),
        .weight_rd_addr(w_rd_addr2), .weight_rd_data(w_rd2),
        .neuron_wr_en(wr_en2), .neuron_wr_addr(wr_addr2), .neuron_wr_data(wr_data2),
        .mlp_done(mlp_done2), .acc_overflow(acc_overflow2)
    );

    // Weight ROM contents.
    initial begin
        for (int i = 0; i < 65536; i++) wmem[i] = 8'h00;
        wmem[16'h0000] = 8'd16;   // 1.0
        wmem[16'h0001] = 8'd16;
        wmem[16'h0002] = 8'd16;
        wmem[16'h0003] = 8'd32;   // 2.0
        wmem[16'h0010] = 8'hE0;   // -2.0
        wmem[16'h0020] = 8'd127;
    end

    // Neuron RAM: synchronous read, written back by the default instance only.
    initial begin
        for (int i = 0; i < 4096; i++) nmem[i] <= 8'h00;
        nmem[12'h000] <= 8'd16;   // 1.0
        nmem[12'h001] <= 8'd32;   // 2.0
        nmem[12'h002] <= 8'hF0;   // -1.0
        nmem[12'h010] <= 8'd16;
        nmem[12'h020] <= 8'd127;
        forever begin
            @(posedge clk);
            n_rd  <= nmem[n_rd_addr];
            w_rd  <= wmem[w_rd_addr];
            n_rd2 <= nmem[n_rd_addr2];
            w_rd2 <= wmem[w_rd_addr2];
            if (wr_en) nmem[wr_addr] <= wr_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Presents one term from a negedge, waits (bounded) for ready, and returns
    // at the negedge after the transfer edge. stalls = low-ready cycles seen.
    task automatic send_term(input logic first, input logic last, input logic [11:0] in_a,
                             input logic [15:0] w_a, input logic [11:0] out_a,
                             output int stalls);
        cmd_valid    = 1'b1;
        cmd_first    = first;
        cmd_last     = last;
        cmd_in_addr  = in_a;
        cmd_w_addr   = w_a;
        cmd_out_addr = out_a;
        stalls       = 0;
        #1;
        while (!cmd_ready && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: cmd_ready stayed %b for %0d cycles, need 1", cmd_ready, stalls);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_first = 1'b0;
        cmd_last  = 1'b0;
    endtask

    // Counts negedges (bounded) until the default instance strobes a write.
    task automatic wait_write(output int cycles);
        cycles = 0;
        while (!wr_en && cycles < 600) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; cmd_valid = 1'b0; cmd_first = 1'b0; cmd_last = 1'b0;
        cmd_in_addr = '0; cmd_w_addr = '0; cmd_out_addr = '0; ctrl_done = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b need 0", wr_en); end
        checks++; if (mlp_done !== 1'b0) begin errors++; $display("FAIL reset_mlp_done: got %b need 0", mlp_done); end
        checks++; if (acc_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b need 0", acc_overflow); end
        checks++; if (n_rd_addr !== 12'h000 || w_rd_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_rd_addr: got %h/%h need 000/0000", n_rd_addr, w_rd_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", cmd_ready); end
    endtask

    // {1,2,-1} x 1.0 -> 2.0 (32), four cycles after the last transfer.
    task automatic test_single_neuron;
        int st, cyc;
        send_term(1'b1, 1'b0, 12'h000, 16'h0000, 12'h400, st);
        send_term(1'b0, 1'b0, 12'h001, 16'h0001, 12'h400, st);
        send_term(1'b0, 1'b1, 12'h002, 16'h0002, 12'h400, st);
        wait_write(cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL single_latency: got %0d cycles need 4", cyc); end
        checks++; if (wr_data !== 8'd32) begin errors++; $display("FAIL single_data: got %h need 20", wr_data); end
        checks++; if (wr_addr !== 12'h400) begin errors++; $display("FAIL single_addr: got %h need 400", wr_addr); end
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_strobe_width: got %b need 0", wr_en); end
    endtask

    // 1.0 x -2.0: clipped to 0 in a hidden layer, kept as -2.0 in the last layer.
    task automatic test_relu;
        int st, cyc;
        send_term(1'b1, 1'b1, 12'h010, 16'h0010, 12'h401, st);
        wait_write(cyc);
        checks++; if (wr_data !== 8'h00 || cyc !== 4) begin
            errors++; $display("FAIL relu_hidden: got data %h after %0d cycles need 00 after 4", wr_data, cyc);
        end
        @(negedge clk);
        send_term(1'b1, 1'b1, 12'h010, 16'h0010, 12'hC01, st);
        wait_write(cyc);
        checks++; if (wr_data !== 8'hE0 || wr_addr !== 12'hC01) begin
            errors++; $display("FAIL relu_last_layer: got %h@%h need e0@c01", wr_data, wr_addr);
        end
        @(negedge clk);
    endtask

    // 2.0 x 2.0 -> 0x400 (old value 2.0, new 4.0), then a read of 0x400 x 1.0.
    task automatic test_hazard;
        int st, cyc;
        send_term(1'b1, 1'b1, 12'h001, 16'h0003, 12'h400, st);
        send_term(1'b1, 1'b1, 12'h400, 16'h0000, 12'h404, st);
        checks++; if (st !== 5) begin errors++; $display("FAIL hazard_stall: got %0d stall cycles need 5", st); end
        wait_write(cyc);
        checks++; if (wr_data !== 8'd64 || wr_addr !== 12'h404) begin
            errors++; $display("FAIL hazard_new_value: got %h@%h need 40@404", wr_data, wr_addr);
        end
        checks++; if (nmem[12'h400] !== 8'd64) begin
            errors++; $display("FAIL hazard_ram: got %h need 40", nmem[12'h400]);
        end
        @(negedge clk);
    endtask

    // Neuron A (1+2 -> 48) followed with no gap by single-term neuron B (4.0 -> 64).
    task automatic test_back_to_back;
        int st, cyc;
        send_term(1'b1, 1'b0, 12'h000, 16'h0000, 12'h405, st);
        send_term(1'b0, 1'b1, 12'h001, 16'h0001, 12'h405, st);
        send_term(1'b1, 1'b1, 12'h001, 16'h0003, 12'h406, st);
        wait_write(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL b2b_first_timing: got %0d need 3", cyc); end
        checks++; if (wr_data !== 8'd48 || wr_addr !== 12'h405) begin
            errors++; $display("FAIL b2b_first: got %h@%h need 30@405", wr_data, wr_addr);
        end
        @(negedge clk);
        checks++; if (wr_en !== 1'b1 || wr_data !== 8'd64 || wr_addr !== 12'h406) begin
            errors++; $display("FAIL b2b_second: got en=%b %h@%h need en=1 40@406", wr_en, wr_data, wr_addr);
        end
        @(negedge clk);
    endtask

    // ctrl_done already high while a term is in flight: mlp_done waits for the drain.
    task automatic test_done_drain;
        int st, cyc;
        ctrl_done = 1'b1;
        send_term(1'b1, 1'b1, 12'h000, 16'h0000, 12'h408, st);
        checks++; if (mlp_done !== 1'b0) begin errors++; $display("FAIL done_early: got %b need 0", mlp_done); end
        wait_write(cyc);
        checks++; if (wr_data !== 8'd16 || cyc !== 4) begin
            errors++; $display("FAIL done_write: got %h after %0d need 10 after 4", wr_data, cyc);
        end
        @(negedge clk);
        checks++; if (mlp_done !== 1'b0) begin errors++; $display("FAIL done_during_write: got %b need 0", mlp_done); end
        @(negedge clk);
        checks++; if (mlp_done !== 1'b1) begin errors++; $display("FAIL done_after_drain: got %b need 1", mlp_done); end
        ctrl_done = 1'b0;
        @(negedge clk);
        checks++; if (mlp_done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b need 1", mlp_done); end
    endtask

    // 432 x (127*127) = 6967728 fits 24 bits but not 16 bits.
    task automatic test_saturation;
        int st, cyc;
        checks++; if (acc_overflow2 !== 1'b0) begin errors++; $display("FAIL sat_pre_flag: got %b need 0", acc_overflow2); end
        for (int i = 0; i < 432; i++) begin
            send_term(i == 0, i == 431, 12'h020, 16'h0020, 12'h407, st);
        end
        wait_write(cyc);
        checks++; if (wr_data !== 8'd127 || cyc !== 4) begin
            errors++; $display("FAIL sat_wide_data: got %h after %0d need 7f after 4", wr_data, cyc);
        end
        checks++; if (acc_overflow !== 1'b0) begin errors++; $display("FAIL sat_wide_flag: got %b need 0", acc_overflow); end
        checks++; if (acc_overflow2 !== 1'b1) begin errors++; $display("FAIL sat_narrow_flag: got %b need 1", acc_overflow2); end
        checks++; if (wr_en2 !== 1'b1 || wr_data2 !== 8'd127) begin
            errors++; $display("FAIL sat_narrow_data: got en=%b %h need en=1 7f", wr_en2, wr_data2);
        end
        @(negedge clk);
    endtask

    // Reset after 5 of 10 terms: nothing is written; done follows ctrl_done.
    task automatic test_reset_mid_neuron;
        int st, writes;
        for (int i = 0; i < 5; i++) begin
            send_term(i == 0, 1'b0, 12'h000, 16'h0000, 12'h409, st);
        end
        reset = 1'b0;
        #1;
        checks++; if (mlp_done !== 1'b0 || acc_overflow2 !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: got done=%b ovf=%b need 0/0", mlp_done, acc_overflow2);
        end
        writes = 0;
        repeat (2) begin
            @(negedge clk);
            if (wr_en) writes++;
        end
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (wr_en) writes++;
        end
        checks++; if (writes !== 0) begin errors++; $display("FAIL midreset_no_write: got %0d writes need 0", writes); end
        ctrl_done = 1'b1;
        #1;
        checks++; if (mlp_done !== 1'b0) begin errors++; $display("FAIL midreset_done_early: got %b need 0", mlp_done); end
        @(negedge clk);
        checks++; if (mlp_done !== 1'b1) begin errors++; $display("FAIL midreset_done: got %b need 1", mlp_done); end
    endtask

    initial begin
        test_reset();
        test_single_neuron();
        test_relu();
        test_hazard();
        test_back_to_back();
        test_done_drain();
        test_saturation();
        test_reset_mid_neuron();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
